// File: rtl/feed_pkg.sv
// Shared widths, task/result records and lane state for the feed dispatcher.
package feed_pkg;

    localparam int BOARD_W  = 64;
    localparam int TASKID_W = 16;
    localparam int RES_W    = 8;
    localparam int NODES_W  = 16;
    localparam int TASK_W   = 2 * BOARD_W + TASKID_W;
    localparam int RESULT_W = RES_W + TASKID_W + NODES_W;

    // Idle-filler tasks carry an all-ones id and are swallowed at the input.
    localparam logic [TASKID_W-1:0] SENTINEL_ID = '1;

    typedef struct packed {
        logic [BOARD_W-1:0]  player;
        logic [BOARD_W-1:0]  opponent;
        logic [TASKID_W-1:0] taskid;
    } task_t;

    typedef struct packed {
        logic signed [RES_W-1:0] res;
        logic [TASKID_W-1:0]     taskid;
        logic [NODES_W-1:0]      nodes;
    } result_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } lane_state_e;

    function automatic logic is_sentinel(input task_t t);
        return t.taskid == SENTINEL_ID;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after base_i, wrapping past N-1 to 0.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] base_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    // Two passes: lanes from base_i upward, then the wrapped lanes below base_i.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_valid_o && req_i[i] && (i >= int'(base_i))) begin
                gnt_o[i]    = 1'b1;
                gnt_idx_o   = PTR_W'(i);
                gnt_valid_o = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_valid_o && req_i[i] && (i < int'(base_i))) begin
                gnt_o[i]    = 1'b1;
                gnt_idx_o   = PTR_W'(i);
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/feed_multi.sv
// Multi-lane task dispatcher and result collector.
// Handshakes (input, lane task, lane result, output) are valid/ready: a transfer
// happens on a rising clock edge where both are high; the valid side keeps its
// data stable until that edge.
module feed_multi
    import feed_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TOTAL_W   = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [TASK_W-1:0]             input_data,
    input  logic                          input_valid,
    output logic                          input_ready,
    output logic [NUM_LANES*TASK_W-1:0]   lane_data,
    output logic [NUM_LANES-1:0]          lane_valid,
    input  logic [NUM_LANES-1:0]          lane_ready,
    input  logic [NUM_LANES*RESULT_W-1:0] lane_res_data,
    input  logic [NUM_LANES-1:0]          lane_res_valid,
    output logic [NUM_LANES-1:0]          lane_res_ready,
    output logic [RESULT_W-1:0]           output_data,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [NUM_LANES-1:0]          busy_lanes,
    output logic [TOTAL_W-1:0]            nodes_total,
    output logic                          proto_err,
    output logic [2*NUM_LANES-1:0]        lane_state_dbg
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int AW    = $clog2(OUT_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

    lane_state_e          state_q [NUM_LANES];
    lane_state_e          state_d [NUM_LANES];
    task_t                task_q  [NUM_LANES];
    result_t              fifo_q  [OUT_DEPTH];
    logic [PTR_W-1:0]     dp_q, dp_d, cp_q, cp_d;
    logic [AW-1:0]        wr_q, rd_q;
    logic [CNT_W-1:0]     count_q;
    logic [TOTAL_W-1:0]   total_q;
    logic                 err_q;

    task_t                in_task;
    logic                 in_sentinel;
    logic [NUM_LANES-1:0] idle_vec, run_vec;
    logic [NUM_LANES-1:0] free_gnt, col_req, col_gnt;
    logic [PTR_W-1:0]     free_idx, col_idx;
    logic                 any_idle, push, pop, dispatch;
    result_t              res_sel, out_res;
    logic [TOTAL_W:0]     sum;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        if (int'(idx) >= NUM_LANES - 1) return '0;
        return idx + 1'b1;
    endfunction

    assign in_task     = task_t'(input_data);
    assign in_sentinel = is_sentinel(in_task);

    // Per-lane status vectors and lane-facing outputs.
    always_comb begin
        idle_vec       = '0;
        run_vec        = '0;
        lane_valid     = '0;
        busy_lanes     = '0;
        lane_data      = '0;
        lane_state_dbg = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idle_vec[i]                    = (state_q[i] == IDLE);
            run_vec[i]                     = (state_q[i] == RUN);
            lane_valid[i]                  = (state_q[i] == ISSUE);
            busy_lanes[i]                  = (state_q[i] != IDLE);
            lane_data[i*TASK_W +: TASK_W]  = task_q[i];
            lane_state_dbg[2*i +: 2]       = state_q[i];
        end
    end

    rr_arbiter #(.N(NUM_LANES), .PTR_W(PTR_W)) u_free_arb (
        .req_i       (idle_vec),
        .base_i      (dp_q),
        .gnt_o       (free_gnt),
        .gnt_idx_o   (free_idx),
        .gnt_valid_o (any_idle)
    );

    // Results are only collected while the FIFO had room at the start of the cycle.
    assign col_req = lane_res_valid & {NUM_LANES{count_q != DEPTH_C}};

    rr_arbiter #(.N(NUM_LANES), .PTR_W(PTR_W)) u_col_arb (
        .req_i       (col_req),
        .base_i      (cp_q),
        .gnt_o       (col_gnt),
        .gnt_idx_o   (col_idx),
        .gnt_valid_o (push)
    );

    assign input_ready    = in_sentinel | any_idle;
    assign dispatch       = input_valid & ~in_sentinel & any_idle;
    assign lane_res_ready = col_gnt;
    assign output_valid   = (count_q != '0);
    assign out_res        = fifo_q[rd_q];
    assign output_data    = output_valid ? out_res : '0;
    assign pop            = output_valid & output_ready;
    assign nodes_total    = total_q;
    assign proto_err      = err_q;
    assign sum            = {1'b0, total_q} + {{(TOTAL_W + 1 - NODES_W){1'b0}}, out_res.nodes};

    // Mux the granted lane's result into the FIFO write port.
    always_comb begin
        res_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (col_gnt[i]) res_sel = result_t'(lane_res_data[i*RESULT_W +: RESULT_W]);
        end
    end

    // Lane FSM next state and pointer advance; stray results leave state untouched.
    always_comb begin
        dp_d = dispatch ? next_ptr(free_idx) : dp_q;
        cp_d = push ? next_ptr(col_idx) : cp_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (dispatch && free_gnt[i]) state_d[i] = ISSUE;
                ISSUE:   if (lane_ready[i]) state_d[i] = RUN;
                RUN:     if (col_gnt[i]) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Lane state, captured tasks and round-robin pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dp_q <= '0;
            cp_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= IDLE;
                task_q[i]  <= '0;
            end
        end else begin
            dp_q <= dp_d;
            cp_q <= cp_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= state_d[i];
                if (dispatch && free_gnt[i]) task_q[i] <= in_task;
            end
        end
    end

    // Output FIFO, saturating node total and sticky protocol error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= res_sel;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q    <= rd_q + 1'b1;
                total_q <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (|(col_gnt & ~run_vec)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_feed_multi.sv
// Directed bench for feed_multi with an expected-result queue and output monitor.
`timescale 1ns/1ps
module tb_feed_multi;
    import feed_pkg::*;

    localparam int NL    = 4;
    localparam int DEPTH = 4;
    localparam int TW    = 20;

    logic                   clock, reset_n;
    logic [TASK_W-1:0]      input_data;
    logic                   input_valid, input_ready;
    logic [NL*TASK_W-1:0]   lane_data;
    logic [NL-1:0]          lane_valid, lane_ready;
    logic [NL*RESULT_W-1:0] lane_res_data;
    logic [NL-1:0]          lane_res_valid, lane_res_ready;
    logic [RESULT_W-1:0]    output_data;
    logic                   output_valid, output_ready;
    logic [NL-1:0]          busy_lanes;
    logic [TW-1:0]          nodes_total;
    logic                   proto_err;
    logic [2*NL-1:0]        lane_state_dbg;

    feed_multi #(.NUM_LANES(NL), .OUT_DEPTH(DEPTH), .TOTAL_W(TW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .input_data     (input_data),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .lane_data      (lane_data),
        .lane_valid     (lane_valid),
        .lane_ready     (lane_ready),
        .lane_res_data  (lane_res_data),
        .lane_res_valid (lane_res_valid),
        .lane_res_ready (lane_res_ready),
        .output_data    (output_data),
        .output_valid   (output_valid),
        .output_ready   (output_ready),
        .busy_lanes     (busy_lanes),
        .nodes_total    (nodes_total),
        .proto_err      (proto_err),
        .lane_state_dbg (lane_state_dbg)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int                  n_checks = 0;
    int                  n_pass   = 0;
    logic [RESULT_W-1:0] exp_q[$];
    logic [TW-1:0]       exp_total;
    logic [NL-1:0]       res_g;
    logic                in_acc;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] a, input logic [NODES_W-1:0] b);
        logic [TW:0] s;
        s = {1'b0, a} + {{(TW + 1 - NODES_W){1'b0}}, b};
        return s[TW] ? {TW{1'b1}} : s[TW-1:0];
    endfunction

    function automatic logic [TASK_W-1:0] mk_task(input logic [15:0] id);
        return {{4{id}}, ~{4{id}}, id};
    endfunction

    function automatic logic [RESULT_W-1:0] mk_res(input logic [7:0] r, input logic [15:0] id,
                                                  input logic [15:0] n);
        return {r, id, n};
    endfunction

    task automatic set_res(input int lane, input logic [RESULT_W-1:0] r);
        lane_res_data[lane*RESULT_W +: RESULT_W] = r;
        lane_res_valid[lane] = 1'b1;
    endtask

    // One clock: sample handshakes at negedge, retire accepted items after the edge.
    task automatic tick();
        @(negedge clock);
        res_g  = lane_res_valid & lane_res_ready;
        in_acc = input_valid & input_ready;
        @(posedge clock);
        #1;
        lane_res_valid = lane_res_valid & ~res_g;
        if (in_acc) input_valid = 1'b0;
    endtask

    // Output monitor: pops the expected queue on every output handshake.
    initial begin
        logic [RESULT_W-1:0] e;
        forever begin
            @(negedge clock);
            if (output_valid && output_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got %0h expected none", output_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", output_data, e);
                    exp_total = sat_add(exp_total, e[NODES_W-1:0]);
                end
            end
        end
    end

    initial begin
        int          lane;
        logic        bad;
        task_t       t;
        reset_n        = 1'b0;
        input_data     = '0;
        input_valid    = 1'b0;
        lane_ready     = '1;
        lane_res_data  = '0;
        lane_res_valid = '0;
        output_ready   = 1'b1;
        exp_total      = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", output_valid, 0);
        check("rst_out_data", output_data, 0);
        check("rst_lane_valid", lane_valid, 0);
        check("rst_res_ready", lane_res_ready, 0);
        check("rst_busy", busy_lanes, 0);
        check("rst_total", nodes_total, 0);
        check("rst_proto", proto_err, 0);
        check("rst_state", lane_state_dbg, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Sentinel is consumed and goes nowhere.
        input_data  = {64'hffff_ffff_ffff_ffff, 64'h0, 16'hffff};
        input_valid = 1'b1;
        #1 check("sent_ready", input_ready, 1);
        tick();
        check("sent_accepted", in_acc, 1);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (lane_valid != '0 || output_valid || busy_lanes != '0) bad = 1'b1;
            tick();
        end
        check("sent_quiet", bad, 0);

        // Tasks 0..3 back to back go to lanes 0..3.
        for (int k = 0; k < 4; k++) begin
            t = task_t'(mk_task(16'(k)));
            input_data  = t;
            input_valid = 1'b1;
            #1 check("disp_ready", input_ready, 1);
            tick();
            check("disp_lane_valid", lane_valid, NL'(1) << k);
            check("disp_lane_data", lane_data[k*TASK_W +: TASK_W], t);
        end
        check("all_busy", busy_lanes, 4'b1111);
        input_data  = mk_task(16'd4);
        input_valid = 1'b1;
        #1 check("full_not_ready", input_ready, 0);
        tick();
        tick();
        check("full_still_not_ready", input_ready, 0);

        // Lanes 0 and 2 finish together: lane 0 first, then lane 2.
        set_res(0, mk_res(8'hf0, 16'd0, 16'd50));
        set_res(2, mk_res(8'd14, 16'd2, 16'd100));
        exp_q.push_back(mk_res(8'hf0, 16'd0, 16'd50));
        exp_q.push_back(mk_res(8'd14, 16'd2, 16'd100));
        #1 check("col_first", lane_res_ready, 4'b0001);
        tick();
        #1 check("col_second", lane_res_ready, 4'b0100);
        check("freed_ready", input_ready, 1);
        tick();
        check("redisp_valid", lane_valid, 4'b0001);
        check("redisp_data", lane_data[0 +: TASK_W], mk_task(16'd4));
        tick();
        tick();
        tick();
        check("order_drained", exp_q.size(), 0);
        check("total_150", nodes_total, 150);

        // Six results against a stalled output: four fill the FIFO, two wait.
        output_ready = 1'b0;
        input_data   = mk_task(16'd5);
        input_valid  = 1'b1;
        tick();
        check("disp5_lane2", lane_valid, 4'b0100);
        tick();
        set_res(3, mk_res(8'd3, 16'd3, 16'd10));
        set_res(0, mk_res(8'd4, 16'd4, 16'd20));
        set_res(1, mk_res(8'h81, 16'd1, 16'd30));
        set_res(2, mk_res(8'd5, 16'd5, 16'd40));
        exp_q.push_back(mk_res(8'd3, 16'd3, 16'd10));
        exp_q.push_back(mk_res(8'd4, 16'd4, 16'd20));
        exp_q.push_back(mk_res(8'h81, 16'd1, 16'd30));
        exp_q.push_back(mk_res(8'd5, 16'd5, 16'd40));
        repeat (4) tick();
        check("fill_out_valid", output_valid, 1);
        check("fill_lanes_idle", busy_lanes, 0);
        input_data  = mk_task(16'd6);
        input_valid = 1'b1;
        tick();
        check("disp6_lane3", lane_valid, 4'b1000);
        input_data  = mk_task(16'd7);
        input_valid = 1'b1;
        tick();
        check("disp7_lane0", lane_valid, 4'b0001);
        tick();
        set_res(3, mk_res(8'd6, 16'd6, 16'd50));
        set_res(0, mk_res(8'd7, 16'd7, 16'd60));
        exp_q.push_back(mk_res(8'd6, 16'd6, 16'd50));
        exp_q.push_back(mk_res(8'd7, 16'd7, 16'd60));
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 if (lane_res_ready != '0) bad = 1'b1;
            tick();
        end
        check("full_no_grant", bad, 0);
        output_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
        check("drain_all", exp_q.size(), 0);
        check("drain_total", nodes_total, 360);
        check("drain_total_model", nodes_total, exp_total);

        // Saturation of the node total.
        for (int n = 0; n < 20; n++) begin
            input_data  = mk_task(16'(16 + n));
            input_valid = 1'b1;
            tick();
            lane = -1;
            for (int i = NL - 1; i >= 0; i--) if (lane_valid[i]) lane = i;
            check("sat_dispatch", lane >= 0, 1);
            if (lane < 0) lane = 0;
            tick();
            set_res(lane, mk_res(8'd1, 16'(16 + n), 16'hffff));
            exp_q.push_back(mk_res(8'd1, 16'(16 + n), 16'hffff));
            tick();
            tick();
        end
        repeat (3) tick();
        check("sat_drain", exp_q.size(), 0);
        check("sat_total", nodes_total, 20'hfffff);
        check("sat_total_model", nodes_total, exp_total);

        // Asynchronous reset in the middle of work.
        output_ready = 1'b0;
        set_res(1, mk_res(8'h11, 16'h0bad, 16'd1));
        tick();
        check("proto_set", proto_err, 1);
        check("proto_pending", output_valid, 1);
        for (int k = 0; k < 4; k++) begin
            input_data  = mk_task(16'(100 + k));
            input_valid = 1'b1;
            tick();
        end
        tick();
        check("all_run_busy", busy_lanes, 4'b1111);
        check("all_run_state", lane_state_dbg, 8'b10101010);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", busy_lanes, 0);
        check("arst_out_valid", output_valid, 0);
        check("arst_out_data", output_data, 0);
        check("arst_lane_valid", lane_valid, 0);
        check("arst_proto", proto_err, 0);
        check("arst_total", nodes_total, 0);
        exp_q.delete();
        exp_total      = '0;
        lane_res_valid = '0;
        input_valid    = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        output_ready = 1'b1;
        set_res(0, mk_res(8'h20, 16'd200, 16'd7));
        set_res(1, mk_res(8'h21, 16'd201, 16'd9));
        exp_q.push_back(mk_res(8'h20, 16'd200, 16'd7));
        exp_q.push_back(mk_res(8'h21, 16'd201, 16'd9));
        repeat (5) tick();
        check("idle_res_proto", proto_err, 1);
        check("idle_res_drain", exp_q.size(), 0);
        check("idle_res_total", nodes_total, 16);
        check("idle_res_busy", busy_lanes, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/feed_multi.md
Name: feed_multi

Overview:
Multi-lane task dispatcher and result collector, the parametrised successor of feed. It accepts {player, opponent, taskid} tasks over valid/ready and issues each to a free solver lane out of NUM_LANES lanes. It gathers {res, taskid, nodes} results from the lanes through a round-robin arbiter into an output FIFO. It also discards idle-filler sentinel tasks and keeps a saturating node total.

Parameters:
NUM_LANES, 4, number of solver lanes (1..16)
BOARD_W, 64, width of each bitboard
TASKID_W, 16, task id width; all-ones id is the sentinel
RES_W, 8, signed result width
NODES_W, 16, per-task node count width
OUT_DEPTH, 4, output FIFO depth (power of two, >=2)
TOTAL_W, 32, width of the node accumulator

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
input_data  in  2*BOARD_W+TASKID_W  {player, opponent, taskid}
input_valid  in  1  task valid
input_ready  out  1  task accepted when valid&ready
lane_data  out  NUM_LANES*(2*BOARD_W+TASKID_W)  per-lane task, lane i at slice i
lane_valid  out  NUM_LANES  per-lane task valid
lane_ready  in  NUM_LANES  per-lane task accept
lane_res_data  in  NUM_LANES*(RES_W+TASKID_W+NODES_W)  per-lane {res, taskid, nodes}
lane_res_valid  in  NUM_LANES  per-lane result valid
lane_res_ready  out  NUM_LANES  per-lane result accept
output_data  out  RES_W+TASKID_W+NODES_W  {res, taskid, nodes}
output_valid  out  1  FIFO non-empty
output_ready  in  1  downstream accept
busy_lanes  out  NUM_LANES  lane state != IDLE
nodes_total  out  TOTAL_W  saturating sum of delivered nodes
proto_err  out  1  sticky: result from an IDLE lane

Behaviour:
- Reset (reset_n low, asynchronous): all lanes IDLE, lane_valid=0, lane_res_ready=0, FIFO empty, output_valid=0, output_data=0, nodes_total=0, proto_err=0, round-robin pointers=0. A reset asserted mid-operation drops all in-flight tasks and FIFO contents.
- Sentinel: an input with taskid = all-ones is consumed (input_ready=1) and never dispatched, counted, or output.
- input_ready is combinational: 1 if the input is a sentinel, else 1 if any lane is IDLE.
- Per-lane FSM:
  - IDLE -> ISSUE on dispatch.
  - ISSUE (lane_valid=1, lane_data held stable) -> RUN on lane_ready.
  - RUN -> IDLE when that lane's result is accepted.
- Dispatch picks the first IDLE lane at or after dispatch pointer dp, wrapping modulo NUM_LANES. On accept, dp moves to the chosen lane+1. lane_valid rises the cycle after acceptance (1-cycle latency).
- Collection: a round-robin arbiter grants one lane per cycle among lanes with lane_res_valid, starting at collect pointer cp. It grants only when the FIFO is not full at the start of the cycle (registered count < OUT_DEPTH). lane_res_ready is combinational and one-hot or zero. After a grant, cp moves to the granted lane+1.
- A result from a lane in IDLE or ISSUE is still accepted and pushed, sets proto_err, and leaves the lane state unchanged.
- FIFO: push on grant, pop on output_valid&output_ready. A push and pop in the same cycle are both allowed; count is unchanged. When full, no grant is given even if a pop occurs in the same cycle. A result appears on output_valid the cycle after its grant.
- nodes_total adds the nodes field on each output handshake and saturates at 2^TOTAL_W-1 with no wrap.
- Output ordering is completion order, not taskid order.

Decomposition:
- Package feed_pkg: BOARD_W/TASKID_W/RES_W/NODES_W constants, SENTINEL_ID, packed structs task_t {player, opponent, taskid} and result_t {res, taskid, nodes}, lane state enum {IDLE, ISSUE, RUN}.
- Sub-module rr_arbiter (NUM_LANES requests, base pointer in, one-hot grant out), instantiated twice: free-lane select and result collect.
- FIFO is inline.

Test Plan:
- Reset then idle, lanes always ready: all outputs 0 and input_ready=1 for sentinel {64'hffff_ffff_ffff_ffff, 0, 16'hffff}; the sentinel produces no lane_valid, and output_valid stays 0 for 20 cycles.
- Tasks id 0..3 issued back-to-back with NUM_LANES=4: dispatched to lanes 0,1,2,3 in order; lane_valid[i] high 1 cycle after each accept. A 5th task sees input_ready=0 until a lane finishes.
- Lanes 2 and 0 return results in the same cycle with cp=0 (id 2 res=14 nodes=100, id 0 res=-16 nodes=50): lane 0 is granted first, then lane 2. Output order is id 0 then id 2, and nodes_total=150.
- output_ready=0 with 6 results pending: the FIFO fills to OUT_DEPTH=4 and lane_res_ready stays 0 for the remaining lanes. Releasing output_ready drains all 6 in arbitration order with none lost.
- Preload nodes_total near 2^32-1 via repeated nodes=16'hffff results: it saturates at 32'hffff_ffff with no wrap.
- reset_n pulsed low mid-RUN on all lanes: busy_lanes=0 and output_valid=0 immediately (asynchronous). Results presented afterwards while lanes are IDLE set proto_err=1.
